rotate_sequencer: RTL and testbench
===================================

# rotate_sequencer

Timed pattern rotator that sits around the parameterized barrel shifter: drives its `a`/`amt` inputs from a pattern register and commits its rotated output `y` back into that register once per prescaler tick. Provides load, enable/pause, direction and step-size control, plus a net-rotation position counter. Target use is LED-chaser / display-scroll demos on the prototyping board. The barrel shifter is instantiated inside this block, so it is a self-contained sequential wrapper.

## Interface
- `N`, 3: log2 of pattern width; `Width = 1 << N` (localparam)
- `Div`, 25_000_000: clock cycles per rotation tick; legal range ≥ 1. Prescaler width `CntW = max(1, $clog2(Div))`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load`  in  1  single-cycle pulse; copies `pattern` into the pattern register
- `pattern`  in  Width  value captured on `load`
- `en`  in  1  1 = rotate on ticks, 0 = pause
- `dir`  in  1  0 = rotate right, 1 = rotate left
- `step`  in  N  rotation distance per tick, 0..Width-1
- `q`  out  Width  current pattern register
- `pos`  out  N  net rotation modulo Width since last load; right is positive
- `tick`  out  1  one-cycle pulse in the cycle a rotation commits
- `running`  out  1  1 while in state RUN

## Operation
- Internal barrel shifter is a combinational right-rotate: `a = q`; `amt = dir ? (Width - step) mod Width : step`, computed in N bits (two's-complement negate of `step`). `y` is the rotated `q`.
- States:
  - IDLE: entered on reset. No ticks. Leave only on `load`.
  - RUN: prescaler counts; a rotation commits on each tick.
  - HOLD: prescaler frozen (not cleared); `q` and `pos` are held.
- Transitions:
  - `load` from any state: go to RUN if `en` = 1, else HOLD.
  - RUN with `en` = 0: go to HOLD.
  - HOLD with `en` = 1: go to RUN.
  - IDLE ignores `en`.
- Prescaler `cnt`:
  - In RUN, `cnt` increments each cycle.
  - When `cnt == Div-1`, `cnt` wraps to 0 and a tick occurs.
  - With `Div` = 1, a tick occurs every RUN cycle.
- On a tick:
  - `q <= y`.
  - `pos <= dir ? pos - step : pos + step`, modulo 2^N; wrap-around is natural.
  - `tick` = 1 for exactly that cycle.
- `step` = 0: the tick still fires; `q` and `pos` are unchanged.
- On `load`: `q <= pattern`, `pos <= 0`, `cnt <= 0`, no tick that cycle.
- Priority: `reset` > `load` > tick rotation > `en` state change. `load` coinciding with a tick discards the rotation.
- `dir` and `step` are sampled only in the tick cycle. Changing them between ticks has no effect on state.
- `en` falling in a tick cycle: that tick still commits; the block enters HOLD next cycle.

## Timing
- Reset values: `q` = 0, `pos` = 0, `cnt` = 0, `tick` = 0, `running` = 0, state = IDLE.
- `tick` is a combinational decode of `state == RUN && cnt == Div-1 && !load`. It is asserted in the same cycle the `q`/`pos` update is scheduled.
- The new `q` is visible one cycle after `tick` is high.
- Load latency: `q` = `pattern` one cycle after `load`. The first tick comes `Div` cycles after the `load` cycle, when `en` is held at 1.
- `running` is registered state, so it follows `en` with 1 cycle of latency.
- The barrel shifter path is purely combinational, from `q` to the D input of `q`. There is no extra pipeline stage.
- Reset asserted mid-run: the next edge returns all state to the reset values, regardless of `load`.

## Test plan
All scenarios use N = 3 and Div = 4.
- Reset then idle: assert `reset` 2 cycles, release, hold `load` = 0, `en` = 1 for 20 cycles -> `q` = 0, `pos` = 0, `tick` never asserts, `running` = 0.
- Right rotate: `load` with `pattern` = 8'h01, `en` = 1, `dir` = 0, `step` = 1.
  - `tick` first asserts 4 cycles after `load`.
  - After 1 tick: `q` = 8'h80, `pos` = 1.
  - After 8 ticks: `q` = 8'h01, `pos` = 0.
- Left rotate with pos wrap: from `q` = 8'h80, `pos` = 1, set `dir` = 1, `step` = 3; one tick -> `q` = 8'h04, `pos` = 6.
- Pause/resume: in RUN with `cnt` = 2, drop `en` for 10 cycles.
  - `q` is held and `tick` stays 0 during the pause.
  - Re-raise `en`: `running` = 1 one cycle later, and `tick` fires 2 cycles after that (prescaler resumes from 2, not 0).
- Load/tick collision: pulse `load` with `pattern` = 8'hA5 exactly in a tick cycle -> `q` = 8'hA5, `pos` = 0, `cnt` = 0, `tick` = 0 that cycle; the next tick comes 4 cycles later.
- Step 0 and Div = 1: rerun with Div = 1, `step` = 0 -> `tick` is high every RUN cycle and `q` is constant. Then set `step` = 5, `dir` = 0 with `q` = 8'h01 -> `q` = 8'h08 on the next cycle.

Source files
------------

// File: rtl/rotate_sequencer.sv
// rotate_sequencer: timed pattern rotator built around a combinational barrel shifter.
// A pattern register drives the shifter. Once per prescaler tick, the rotated value is
// committed back into the register. The block also tracks net rotation since the last
// load.
//
// Parameters:
//   N       log2 of the pattern width (Width = 1 << N)
//   Div     clock cycles per rotation tick (>= 1)
// Ports:
//   clk      system clock; all state updates on the rising edge
//   reset    synchronous, active-high reset
//   load     single-cycle pulse; captures pattern, clears pos and prescaler
//   pattern  value captured on load
//   en       1 = rotate on ticks, 0 = pause
//   dir      0 = rotate right, 1 = rotate left
//   step     rotation distance per tick
//   q        current pattern register
//   pos      net rotation modulo Width since last load (right is positive)
//   tick     one-cycle pulse in the cycle a rotation commits
//   running  high while in the run state
module rotate_sequencer #(
    parameter int unsigned N   = 3,
    parameter int unsigned Div = 25_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [(1<<N)-1:0]   pattern,
    input  logic                en,
    input  logic                dir,
    input  logic [N-1:0]        step,
    output logic [(1<<N)-1:0]   q,
    output logic [N-1:0]        pos,
    output logic                tick,
    output logic                running
);

    localparam int unsigned Width = 1 << N;
    localparam int unsigned CntW  = (Div <= 1) ? 1 : $clog2(Div);
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [Width-1:0]  q_q, q_d;
    logic [N-1:0]      pos_q, pos_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Barrel shifter: a left rotate by step is a right rotate by -step (mod Width).
    logic [N-1:0]          amt;
    logic [N:0][Width-1:0] stage;
    logic [Width-1:0]      y;

    assign amt      = dir ? ({N{1'b0}} - step) : step;
    assign stage[0] = q_q;

    for (genvar k = 0; k < N; k++) begin : g_rot
        localparam int unsigned Sh = 1 << k;
        assign stage[k+1] = amt[k] ? {stage[k][Sh-1:0], stage[k][Width-1:Sh]} : stage[k];
    end

    assign y = stage[N];

    // Load suppresses the tick so a colliding rotation is discarded.
    assign tick = (state_q == StRun) && (cnt_q == CntMax) && !load;

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;

        if (load) begin
            q_d     = pattern;
            pos_d   = '0;
            cnt_d   = '0;
            state_d = en ? StRun : StHold;
        end else begin
            case (state_q)
                StRun: begin
                    if (tick) begin
                        q_d   = y;
                        pos_d = dir ? (pos_q - step) : (pos_q + step);
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    // A tick in this cycle still commits; pause takes effect next cycle.
                    if (!en) begin
                        state_d = StHold;
                    end
                end
                StHold: begin
                    // Prescaler is frozen here, so resuming continues the partial period.
                    if (en) begin
                        state_d = StRun;
                    end
                end
                StIdle: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            q_q     <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q       = q_q;
    assign pos     = pos_q;
    assign running = (state_q == StRun);

endmodule

// File: tb/tb_rotate_sequencer.sv
// Testbench for rotate_sequencer: two instances (Div = 4 and Div = 1) share stimulus.
// A cycle-level reference model predicts each cycle's outputs into a scoreboard queue,
// which is popped and compared after the clock edge; directed checks cover the key
// literal values.
module tb_rotate_sequencer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] pattern;
    logic       en;
    logic       dir;
    logic [2:0] step;

    logic [7:0] q4, q1;
    logic [2:0] pos4, pos1;
    logic       tick4, tick1;
    logic       run4, run1;

    int n_checks = 0;
    int n_errors = 0;

    rotate_sequencer #(.N(3), .Div(4)) u_dut4 (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .pattern (pattern),
        .en      (en),
        .dir     (dir),
        .step    (step),
        .q       (q4),
        .pos     (pos4),
        .tick    (tick4),
        .running (run4)
    );

    rotate_sequencer #(.N(3), .Div(1)) u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .pattern (pattern),
        .en      (en),
        .dir     (dir),
        .step    (step),
        .q       (q1),
        .pos     (pos1),
        .tick    (tick1),
        .running (run1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         chk_tick;
        logic       t0, t1;
        logic [7:0] q0, q1;
        logic [2:0] p0, p1;
        logic       r0, r1;
    } exp_t;

    exp_t sb[$];

    // Reference model state: index 0 is the Div = 4 instance, 1 the Div = 1 instance.
    // States: 0 = idle, 1 = run, 2 = hold.
    int         m_state[2];
    int         m_cnt[2];
    logic [7:0] m_q[2];
    int         m_pos[2];
    int         divs[2] = '{4, 1};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rot_right(input logic [7:0] v, input int amt);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[(i + amt) % 8];
        end
        return r;
    endfunction

    // One clock cycle with the currently driven inputs. Returns the pre-edge ticks.
    task automatic run_cycle(output logic t4o, output logic t1o);
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            logic mt;
            int   amt;
            mt = (m_state[k] == 1) && (m_cnt[k] == divs[k] - 1) && !load;
            if (k == 0) e.t0 = mt; else e.t1 = mt;
            if (reset) begin
                m_state[k] = 0;
                m_cnt[k]   = 0;
                m_q[k]     = 8'h00;
                m_pos[k]   = 0;
            end else if (load) begin
                m_q[k]     = pattern;
                m_pos[k]   = 0;
                m_cnt[k]   = 0;
                m_state[k] = en ? 1 : 2;
            end else if (m_state[k] == 1) begin
                if (mt) begin
                    amt      = dir ? (8 - int'(step)) % 8 : int'(step);
                    m_q[k]   = rot_right(m_q[k], amt);
                    m_pos[k] = dir ? (m_pos[k] + 8 - int'(step)) % 8 : (m_pos[k] + int'(step)) % 8;
                    m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
                if (!en) m_state[k] = 2;
            end else if (m_state[k] == 2 && en) begin
                m_state[k] = 1;
            end
        end
        e.chk_tick = !reset;
        e.q0 = m_q[0];
        e.q1 = m_q[1];
        e.p0 = 3'(m_pos[0]);
        e.p1 = 3'(m_pos[1]);
        e.r0 = (m_state[0] == 1);
        e.r1 = (m_state[1] == 1);
        sb.push_back(e);

        #2;
        t4o = tick4;
        t1o = tick1;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk_tick) begin
            check_val("tick_d4", 32'(t4o), 32'(e.t0));
            check_val("tick_d1", 32'(t1o), 32'(e.t1));
        end
        check_val("q_d4", 32'(q4), 32'(e.q0));
        check_val("pos_d4", 32'(pos4), 32'(e.p0));
        check_val("running_d4", 32'(run4), 32'(e.r0));
        check_val("q_d1", 32'(q1), 32'(e.q1));
        check_val("pos_d1", 32'(pos1), 32'(e.p1));
        check_val("running_d1", 32'(run1), 32'(e.r1));
    endtask

    // Run until the Div = 4 instance ticks, bounded.
    task automatic wait_tick(output int cycles);
        logic t4, t1;
        cycles = 0;
        t4 = 1'b0;
        while (!t4 && cycles < 10) begin
            run_cycle(t4, t1);
            cycles++;
        end
        if (!t4) check_val("tick_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        logic t4, t1;
        logic seen;
        int   n;

        reset   = 1'b1;
        load    = 1'b0;
        en      = 1'b1;
        dir     = 1'b0;
        step    = 3'd1;
        pattern = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_cnt[k]   = 0;
            m_q[k]     = 8'h00;
            m_pos[k]   = 0;
        end

        // Reset then idle with en held high.
        run_cycle(t4, t1);
        run_cycle(t4, t1);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (20) begin
            run_cycle(t4, t1);
            seen = seen | t4 | t1;
        end
        check_val("idle_tick", 32'(seen), 32'(0));
        check_val("idle_q", 32'(q4), 32'h00);
        check_val("idle_pos", 32'(pos4), 32'(0));
        check_val("idle_running", 32'(run4), 32'(0));

        // Right rotate by 1.
        pattern = 8'h01;
        load    = 1'b1;
        run_cycle(t4, t1);
        load = 1'b0;
        wait_tick(n);
        check_val("first_tick_latency", 32'(n), 32'(4));
        check_val("right1_q", 32'(q4), 32'h80);
        check_val("right1_pos", 32'(pos4), 32'(1));
        repeat (7) wait_tick(n);
        check_val("right8_q", 32'(q4), 32'h01);
        check_val("right8_pos", 32'(pos4), 32'(0));
        wait_tick(n);
        check_val("right9_q", 32'(q4), 32'h80);

        // Left rotate by 3 with pos wrap.
        dir  = 1'b1;
        step = 3'd3;
        wait_tick(n);
        check_val("left3_q", 32'(q4), 32'h04);
        check_val("left3_pos", 32'(pos4), 32'(6));

        // Pause with the prescaler frozen at 2, then resume.
        run_cycle(t4, t1);
        en   = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            run_cycle(t4, t1);
            seen = seen | t4;
        end
        check_val("pause_tick", 32'(seen), 32'(0));
        check_val("pause_q", 32'(q4), 32'h04);
        check_val("pause_running", 32'(run4), 32'(0));
        en = 1'b1;
        run_cycle(t4, t1);
        check_val("resume_running", 32'(run4), 32'(1));
        run_cycle(t4, t1);
        check_val("resume_early_tick", 32'(t4), 32'(0));
        run_cycle(t4, t1);
        check_val("resume_tick", 32'(t4), 32'(1));

        // Load colliding with a tick.
        n = 0;
        while (m_cnt[0] != 3 && n < 8) begin
            run_cycle(t4, t1);
            n++;
        end
        pattern = 8'hA5;
        load    = 1'b1;
        run_cycle(t4, t1);
        load = 1'b0;
        check_val("collide_tick", 32'(t4), 32'(0));
        check_val("collide_q", 32'(q4), 32'hA5);
        check_val("collide_pos", 32'(pos4), 32'(0));
        wait_tick(n);
        check_val("collide_next_tick", 32'(n), 32'(4));

        // Div = 1: step 0 keeps q, then step 5 right.
        dir     = 1'b0;
        step    = 3'd0;
        pattern = 8'h01;
        load    = 1'b1;
        run_cycle(t4, t1);
        load = 1'b0;
        repeat (5) begin
            run_cycle(t4, t1);
            check_val("div1_tick", 32'(t1), 32'(1));
            check_val("div1_q_const", 32'(q1), 32'h01);
        end
        step = 3'd5;
        run_cycle(t4, t1);
        check_val("div1_step5_q", 32'(q1), 32'h08);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
